gps_ca_code_gen: RTL
====================

// Module: gps_ca_code_gen
// PURPOSE
//  GPS L1 C/A Gold-code generator; consumer of the 1.023 MHz code clock from the code NCO.
//  Runs entirely in the clkin domain: detects rising edges of clk_ca_1023 and advances G1/G2 one chip per edge.
//  Outputs the PRN-selected chip stream, the chip index and a 1 ms epoch strobe to the modulator/correlator.
// PARAMETERS
//  DEFAULT_PRN  6'd1     PRN used after reset (must be 1..32)
//  CA_LEN       1023     chips per code period; fixed by the ICD, exposed for the bench only
// PORTS
//  clkin        in   1   system clock (same clock as the code NCO)
//  rst          in   1   asynchronous reset, active-low
//  clk_ca_1023  in   1   code clock from the NCO, registered in the clkin domain; no synchroniser
//  en           in   1   1 = advance on code edges; 0 = freeze all state (edges are dropped, not queued)
//  prn_sel      in   6   requested PRN, 1..32
//  prn_load     in   1   1-cycle strobe: latch prn_sel and restart the code
//  ca_chip      out  1   current C/A chip (1 = logic one)
//  chip_idx     out  10  index of the current chip, 0..1022
//  epoch        out  1   1-cycle pulse when chip_idx wraps 1022->0
//  prn_cur      out  6   PRN currently generated
//  prn_err      out  1   1-cycle pulse: prn_load with prn_sel outside 1..32
// BEHAVIOUR
//  Reset: G1=G2=10'h3FF, chip_idx=0, prn_cur=DEFAULT_PRN, epoch=0, prn_err=0, clk_d=0;
//   ca_chip is then the first chip of DEFAULT_PRN.
//  Edge detect: clk_d <= clk_ca_1023 each cycle; tick = clk_ca_1023 & ~clk_d & en.
//  G1 feedback = g1[3]^g1[10]. G2 feedback = g2[2]^g2[3]^g2[6]^g2[8]^g2[9]^g2[10].
//   Stages are numbered 1..10; shift toward stage 10; feedback enters stage 1.
//  ca_chip = g1[10] ^ g2[s1] ^ g2[s2]. (s1,s2) come from the ICD phase-select table indexed by prn_cur.
//   Examples: PRN1 (2,6), PRN2 (3,7), PRN3 (4,8), PRN4 (5,9), PRN5 (1,9).
//   ca_chip is combinational from registered state, so it has no extra register stage.
//  Latency: tick high in cycle N -> registers update at the end of N -> new chip and chip_idx visible in N+1.
//  Wrap: tick with chip_idx==1022 -> chip_idx=0; G1 and G2 are forced to 3FF; epoch=1 in cycle N+1 only.
//   The forced reload must equal the natural LFSR state; a mismatch is a bench assertion failure.
//  prn_load with prn_sel in 1..32:
//   - next cycle: prn_cur=prn_sel, G1=G2=3FF, chip_idx=0, epoch=0.
//   - prn_load wins over a same-cycle tick; that tick is dropped.
//  prn_load with prn_sel==0 or >32: state unchanged, prn_err=1 for one cycle. Same-cycle tick is processed normally.
//  en=0: edges are ignored, but clk_d still tracks clk_ca_1023.
//   So raising en while clk_ca_1023 is already high produces no spurious tick.
//  prn_load is honoured regardless of en.
//  Async reset mid-code: immediate return to reset values; the first tick after release produces chip index 1.
//  Input precondition: at most one rising edge of clk_ca_1023 per 2 clkin cycles (NCO toggle rate < clkin/2).
// STRUCTURE
//  Shared package gps_ca_pkg holds:
//   - G1_TAPS/G2_TAPS polynomial constants, CA_LEN, PRN_MIN/PRN_MAX.
//   - the 32-entry G2 phase-select table as a function returning {s1,s2}.
//  One sub-module: gps_g2_tap_sel (combinational prn_cur -> two 10:1 muxes over g2 -> g2 tap XOR).
//   It is reused later by the correlator replica.
//  Top level holds: edge detect, G1/G2 registers, chip counter, PRN register, epoch/err pulses.
// TESTING
//  T1 reset, PRN1, en=1, NCO edges -> first 10 chips 1100100000 (octal 1440).
//     Chip 0 appears before the first tick.
//  T2 prn_load with prn_sel=2 -> next cycle chip_idx=0, prn_cur=2; first 10 chips 1110010000 (octal 1620).
//     Repeat for PRN3=1710 and PRN4=1744.
//  T3 run 3 full periods -> epoch pulses exactly every 1023 ticks, one cycle wide, with chip_idx=0.
//     G1=G2=3FF at each wrap; period-1 sequence equals period-2 sequence bit for bit.
//  T4 prn_load on the same cycle as a tick at chip_idx=500 -> tick dropped, chip_idx=0.
//     Then prn_sel=0 or 33 -> prn_err one cycle, prn_cur and chip_idx unchanged.
//  T5 en=0 for 7 code edges, then en=1 while clk_ca_1023 is high -> chip_idx unchanged, no tick on re-enable.
//     Count resumes at the next rising edge.
//  T6 async rst asserted mid-period (chip_idx=700) -> outputs return to reset values within the same cycle.
//     After release, the chip sequence matches T1.
//  All PRNs 1..32: compare the full 1023-chip sequence against a reference model.
//   Cross-correlation check: all 1023 chips between PRN1 and PRN2 differ in ~512 positions.

Source files
------------

// File: rtl/gps_ca_pkg.sv
`default_nettype none
// ============================================================================
// Module  : gps_ca_pkg
// Brief   : GPS L1 C/A shared constants and G2 phase-select table.
// Revision: 1.0 - initial release
// ============================================================================
package gps_ca_pkg;

    // Tap masks: bit (k-1) represents LFSR stage k.
    localparam logic [9:0] G1_TAPS   = 10'h204;
    localparam logic [9:0] G2_TAPS   = 10'h3A6;
    localparam logic [9:0] LFSR_INIT = 10'h3FF;
    localparam int         CA_LEN    = 1023;
    localparam logic [5:0] PRN_MIN   = 6'd1;
    localparam logic [5:0] PRN_MAX   = 6'd32;

    typedef struct packed {
        logic [3:0] s1;
        logic [3:0] s2;
    } g2_phase_t;

    function automatic g2_phase_t g2_phase_sel(input logic [5:0] prn);
        g2_phase_t ph;
        case (prn)
            6'd1:    ph = '{4'd2, 4'd6};
            6'd2:    ph = '{4'd3, 4'd7};
            6'd3:    ph = '{4'd4, 4'd8};
            6'd4:    ph = '{4'd5, 4'd9};
            6'd5:    ph = '{4'd1, 4'd9};
            6'd6:    ph = '{4'd2, 4'd10};
            6'd7:    ph = '{4'd1, 4'd8};
            6'd8:    ph = '{4'd2, 4'd9};
            6'd9:    ph = '{4'd3, 4'd10};
            6'd10:   ph = '{4'd2, 4'd3};
            6'd11:   ph = '{4'd3, 4'd4};
            6'd12:   ph = '{4'd5, 4'd6};
            6'd13:   ph = '{4'd6, 4'd7};
            6'd14:   ph = '{4'd7, 4'd8};
            6'd15:   ph = '{4'd8, 4'd9};
            6'd16:   ph = '{4'd9, 4'd10};
            6'd17:   ph = '{4'd1, 4'd4};
            6'd18:   ph = '{4'd2, 4'd5};
            6'd19:   ph = '{4'd3, 4'd6};
            6'd20:   ph = '{4'd4, 4'd7};
            6'd21:   ph = '{4'd5, 4'd8};
            6'd22:   ph = '{4'd6, 4'd9};
            6'd23:   ph = '{4'd1, 4'd3};
            6'd24:   ph = '{4'd4, 4'd6};
            6'd25:   ph = '{4'd5, 4'd7};
            6'd26:   ph = '{4'd6, 4'd8};
            6'd27:   ph = '{4'd7, 4'd9};
            6'd28:   ph = '{4'd8, 4'd10};
            6'd29:   ph = '{4'd1, 4'd6};
            6'd30:   ph = '{4'd2, 4'd7};
            6'd31:   ph = '{4'd3, 4'd8};
            6'd32:   ph = '{4'd4, 4'd9};
            default: ph = '{4'd2, 4'd6};
        endcase
        return ph;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gps_g2_tap_sel.sv
`default_nettype none
// ============================================================================
// Module  : gps_g2_tap_sel
// Brief   : Selects the two PRN-specific G2 stages and XORs them.
// Revision: 1.0 - initial release
// ============================================================================
module gps_g2_tap_sel
    import gps_ca_pkg::*;
(
    input  logic [5:0] prn,
    input  logic [9:0] g2,
    output logic       tap
);

    g2_phase_t w_phase;
    logic      w_bit_a;
    logic      w_bit_b;

    always_comb begin
        w_phase = g2_phase_sel(prn);
        w_bit_a = 1'b0;
        w_bit_b = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (w_phase.s1 == 4'(i + 1)) w_bit_a = g2[i];
            if (w_phase.s2 == 4'(i + 1)) w_bit_b = g2[i];
        end
        tap = w_bit_a ^ w_bit_b;
    end

endmodule
`default_nettype wire

// File: rtl/gps_ca_code_gen.sv
`default_nettype none
// ============================================================================
// Module  : gps_ca_code_gen
// Brief   : GPS L1 C/A Gold-code generator advanced by code-clock rising edges.
// Revision: 1.0 - initial release
// ============================================================================
module gps_ca_code_gen
    import gps_ca_pkg::*;
#(
    parameter logic [5:0] DEFAULT_PRN = 6'd1,
    parameter int         CA_LEN      = gps_ca_pkg::CA_LEN
) (
    input  logic       clkin,
    input  logic       rst,
    input  logic       clk_ca_1023,
    input  logic       en,
    input  logic [5:0] prn_sel,
    input  logic       prn_load,
    output logic       ca_chip,
    output logic [9:0] chip_idx,
    output logic       epoch,
    output logic [5:0] prn_cur,
    output logic       prn_err
);

    localparam logic [9:0] C_LAST_IDX = 10'(CA_LEN - 1);

    logic       r_clk_d_q;
    logic [9:0] r_g1_q, w_g1_d;
    logic [9:0] r_g2_q, w_g2_d;
    logic [9:0] r_idx_q, w_idx_d;
    logic [5:0] r_prn_q, w_prn_d;
    logic       r_epoch_q, w_epoch_d;
    logic       r_err_q, w_err_d;
    logic       w_tick;
    logic       w_prn_ok;
    logic       w_load;
    logic       w_g2_tap;

    assign w_tick   = clk_ca_1023 & ~r_clk_d_q & en;
    assign w_prn_ok = (prn_sel >= PRN_MIN) && (prn_sel <= PRN_MAX);
    assign w_load   = prn_load & w_prn_ok;

    always_comb begin
        w_g1_d    = r_g1_q;
        w_g2_d    = r_g2_q;
        w_idx_d   = r_idx_q;
        w_prn_d   = r_prn_q;
        w_epoch_d = 1'b0;
        w_err_d   = prn_load & ~w_prn_ok;
        if (w_load) begin
            // A valid load restarts the code and swallows any coincident tick.
            w_prn_d = prn_sel;
            w_g1_d  = LFSR_INIT;
            w_g2_d  = LFSR_INIT;
            w_idx_d = '0;
        end else if (w_tick) begin
            if (r_idx_q == C_LAST_IDX) begin
                w_idx_d   = '0;
                w_g1_d    = LFSR_INIT;
                w_g2_d    = LFSR_INIT;
                w_epoch_d = 1'b1;
            end else begin
                w_idx_d = r_idx_q + 10'd1;
                w_g1_d  = {r_g1_q[8:0], ^(r_g1_q & G1_TAPS)};
                w_g2_d  = {r_g2_q[8:0], ^(r_g2_q & G2_TAPS)};
            end
        end
    end

    always_ff @(posedge clkin or negedge rst) begin
        if (!rst) begin
            r_clk_d_q <= 1'b0;
            r_g1_q    <= LFSR_INIT;
            r_g2_q    <= LFSR_INIT;
            r_idx_q   <= '0;
            r_prn_q   <= DEFAULT_PRN;
            r_epoch_q <= 1'b0;
            r_err_q   <= 1'b0;
        end else begin
            r_clk_d_q <= clk_ca_1023;
            r_g1_q    <= w_g1_d;
            r_g2_q    <= w_g2_d;
            r_idx_q   <= w_idx_d;
            r_prn_q   <= w_prn_d;
            r_epoch_q <= w_epoch_d;
            r_err_q   <= w_err_d;
        end
    end

    gps_g2_tap_sel u_g2_tap_sel (
        .prn (r_prn_q),
        .g2  (r_g2_q),
        .tap (w_g2_tap)
    );

    assign ca_chip  = r_g1_q[9] ^ w_g2_tap;
    assign chip_idx = r_idx_q;
    assign epoch    = r_epoch_q;
    assign prn_cur  = r_prn_q;
    assign prn_err  = r_err_q;

endmodule
`default_nettype wire
